// File: rtl/cic_dec_core.sv
// ---------------------------------------------------------------------------
// cic_dec_core
//
// Purpose: 4-stage CIC decimator (integrate -> decimate -> comb) for the DDC
// receive chain. Produces the full-precision bw+maxbitgain word; the
// downstream shifter normalises it using the same rate value.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   enable      in   run; low synchronously clears all state
//   rate        in   decimation rate 1..128 (0 behaves as 1)
//   strobe_in   in   input sample valid, one cycle per sample
//   signal_in   in   signed input sample, bw bits
//   strobe_out  out  one-cycle pulse marking a new decimated sample
//   signal_out  out  signed decimated sample, bw+maxbitgain bits
//
// Optional feature (macro CIC_DEC_RATE_RESYNC_EN): when defined, a change of
// rate while enabled restarts the decimation group and flushes the comb
// delays, so the first group after the change is exactly eff_rate inputs.
// When undefined the new rate simply applies at the next counter compare.
// ---------------------------------------------------------------------------
module cic_dec_core #(
    parameter int bw               = 16,
    parameter int N                = 4,
    parameter int log2_of_max_rate = 7,
    parameter int maxbitgain       = 28
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [7:0]                      rate,
    input  logic                            strobe_in,
    input  logic signed [bw-1:0]            signal_in,
    output logic                            strobe_out,
    output logic signed [bw+maxbitgain-1:0] signal_out
);

    localparam int W    = bw + maxbitgain;
    localparam int CntW = log2_of_max_rate + 1;

    logic signed [W-1:0] integ_q [N];
    logic signed [W-1:0] integ_d [N];
    logic signed [W-1:0] dly_q   [N];
    logic signed [W-1:0] dly_d   [N];
    logic signed [W-1:0] comb_q  [N];
    logic signed [W-1:0] comb_d  [N];
    logic signed [W-1:0] stg_in  [N];
    logic [N-1:0]        stg_vld;
    logic [N-1:0]        vld_q, vld_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                smp_q, smp_d;
    logic                stb_q, stb_d;
    logic signed [W-1:0] out_q, out_d;
    logic [7:0]          eff_rate;
    logic                rate_chg;

    assign eff_rate = (rate == 8'd0) ? 8'd1 : rate;

`ifdef CIC_DEC_RATE_RESYNC_EN
    // Previous-cycle rate; tracks regardless of enable so that only genuine
    // changes seen while running trigger a resync.
    logic [7:0] rate_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rate_q <= 8'd0;
        end else begin
            rate_q <= rate;
        end
    end

    assign rate_chg = enable && (rate != rate_q);
`else
    assign rate_chg = 1'b0;
`endif

    always_comb begin
        integ_d = integ_q;
        dly_d   = dly_q;
        comb_d  = comb_q;
        cnt_d   = cnt_q;
        smp_d   = 1'b0;
        vld_d   = '0;
        stb_d   = 1'b0;
        out_d   = out_q;
        stg_vld = '0;
        for (int k = 0; k < N; k++) begin
            stg_in[k] = '0;
        end

        if (!enable) begin
            for (int k = 0; k < N; k++) begin
                integ_d[k] = '0;
                dly_d[k]   = '0;
                comb_d[k]  = '0;
            end
            cnt_d = '0;
            out_d = '0;
        end else begin
            // Integrator cascade: each stage adds the previous stage's old value.
            if (strobe_in) begin
                integ_d[0] = integ_q[0] + W'(signal_in);
                for (int k = 1; k < N; k++) begin
                    integ_d[k] = integ_q[k] + integ_q[k-1];
                end
                // >= (not ==) so a lowered rate mid-group still terminates.
                if (cnt_q >= CntW'(eff_rate - 8'd1)) begin
                    cnt_d = '0;
                    smp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Comb pipeline: stage 0 takes the last integrator on the
            // decimation strobe, later stages take the previous comb output.
            stg_in[0]  = integ_q[N-1];
            stg_vld[0] = smp_q;
            for (int k = 1; k < N; k++) begin
                stg_in[k]  = comb_q[k-1];
                stg_vld[k] = vld_q[k-1];
            end
            for (int k = 0; k < N; k++) begin
                vld_d[k] = stg_vld[k];
                if (stg_vld[k]) begin
                    comb_d[k] = stg_in[k] - dly_q[k];
                    dly_d[k]  = stg_in[k];
                end
            end

            stb_d = vld_q[N-1];
            if (vld_q[N-1]) begin
                out_d = comb_q[N-1];
            end

            if (rate_chg) begin
                cnt_d = '0;
                smp_d = 1'b0;
                for (int k = 0; k < N; k++) begin
                    dly_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
                comb_q[k]  <= '0;
            end
            cnt_q <= '0;
            smp_q <= 1'b0;
            vld_q <= '0;
            stb_q <= 1'b0;
            out_q <= '0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            comb_q  <= comb_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            vld_q   <= vld_d;
            stb_q   <= stb_d;
            out_q   <= out_d;
        end
    end

    assign strobe_out = stb_q;
    assign signal_out = out_q;

endmodule

// File: tb/tb_cic_dec_core.sv
// ---------------------------------------------------------------------------
// tb_cic_dec_core
//
// Scoreboard bench for cic_dec_core. A sample-level reference model (running
// sums, a group counter and four first differences on the decimated stream)
// pushes each expected output value together with the cycle it must appear
// in; a separate monitor pops and compares whenever strobe_out is seen.
// ---------------------------------------------------------------------------
module tb_cic_dec_core;

    localparam int bw         = 16;
    localparam int N          = 4;
    localparam int LOG2R      = 7;
    localparam int maxbitgain = 28;
    localparam int W          = bw + maxbitgain;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   enable;
    logic [7:0]             rate;
    logic                   strobe_in;
    logic signed [bw-1:0]   signal_in;
    logic                   strobe_out;
    logic signed [W-1:0]    signal_out;

    always #5 clock = ~clock;

    cic_dec_core #(
        .bw(bw), .N(N), .log2_of_max_rate(LOG2R), .maxbitgain(maxbitgain)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .rate(rate),
        .strobe_in(strobe_in), .signal_in(signal_in),
        .strobe_out(strobe_out), .signal_out(signal_out)
    );

    typedef struct {
        logic signed [W-1:0] val;
        int                  c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   first_out_cyc = -1;
    int   first_stb_cyc = -1;
    logic signed [W-1:0] last_val = '0;

    // ---------------- reference model ----------------
    logic signed [W-1:0] m_int [N];
    logic signed [W-1:0] m_dly [N];
    int                  m_cnt;
    logic [7:0]          m_prev_rate;

    always @(posedge clock or negedge reset_n) begin
        logic signed [W-1:0] x, v, t;
        int  eff;
        bit  emit, chg;
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                m_int[k] = '0;
                m_dly[k] = '0;
            end
            m_cnt = 0;
            m_prev_rate = 8'd0;
            q.delete();
        end else begin
            cyc = cyc + 1;
            if (!enable) begin
                for (int k = 0; k < N; k++) begin
                    m_int[k] = '0;
                    m_dly[k] = '0;
                end
                m_cnt = 0;
                q.delete();
            end else begin
                eff  = (rate == 0) ? 1 : int'(rate);
                emit = 1'b0;
`ifdef CIC_DEC_RATE_RESYNC_EN
                chg = (rate != m_prev_rate);
`else
                chg = 1'b0;
`endif
                if (strobe_in) begin
                    x = signal_in;
                    for (int k = N - 1; k >= 1; k--) m_int[k] = m_int[k] + m_int[k-1];
                    m_int[0] = m_int[0] + x;
                    if (m_cnt >= eff - 1) begin
                        m_cnt = 0;
                        emit  = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                if (chg) begin
                    m_cnt = 0;
                    emit  = 1'b0;
                    for (int k = 0; k < N; k++) m_dly[k] = '0;
                end
                if (emit) begin
                    v = m_int[N-1];
                    for (int k = 0; k < N; k++) begin
                        t        = v - m_dly[k];
                        m_dly[k] = v;
                        v        = t;
                    end
                    q.push_back('{val: v, c: cyc + N + 1});
                end
            end
            m_prev_rate = rate;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && strobe_out) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got %0d at cyc %0d, required no output", signal_out, cyc);
            end else begin
                e = q.pop_front();
                if (signal_out !== e.val || cyc != e.c) begin
                    n_err++;
                    $display("FAIL out_%0d: got %0d at cyc %0d, required %0d at cyc %0d",
                             n_out, signal_out, cyc, e.val, e.c);
                end
            end
            last_val = signal_out;
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input logic signed [W-1:0] got,
                         input logic signed [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // per: <0 no strobes, 0 random strobes, >0 strobe every per-th cycle
    // dmode: 0 constant dc, 1 ramp, 2 random
    task automatic drive(input int ncyc, input int per, input int dmode,
                         input logic signed [bw-1:0] dc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            if (per < 0)       strobe_in = 1'b0;
            else if (per == 0) strobe_in = 1'($urandom_range(0, 1));
            else               strobe_in = ((i % per) == 0);
            case (dmode)
                0:       signal_in = dc;
                1:       signal_in = bw'(i);
                default: signal_in = bw'($urandom);
            endcase
            if (strobe_in && first_stb_cyc < 0) first_stb_cyc = cyc + 1;
        end
    endtask

    task automatic restart(input logic [7:0] r);
        @(negedge clock);
        enable    = 1'b0;
        strobe_in = 1'b0;
        rate      = r;
        @(negedge clock);
        @(negedge clock);
        enable = 1'b1;
    endtask

    initial begin
        logic signed [W-1:0] min_val;
        int k_exp;
        min_val   = '0;
        min_val[W-1] = 1'b1;
        reset_n   = 1'b0;
        enable    = 1'b0;
        rate      = 8'd1;
        strobe_in = 1'b0;
        signal_in = '0;
        #22;
        check("reset_strobe_out", W'(strobe_out), '0);
        check("reset_signal_out", signal_out, '0);
        @(negedge clock);
        reset_n = 1'b1;

        // rate=4, constant 1, continuous strobes: settles to 4^4
        restart(8'd4);
        drive(4 * 8, 1, 0, 16'sd1);
        drive(8, -1, 0, '0);
        check("rate4_dc_gain", last_val, 44'sd256);

        // asynchronous reset with no clock edge
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_strobe_out", W'(strobe_out), '0);
        check("async_rst_signal_out", signal_out, '0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // rate=128, most negative input: exactly -2^43
        restart(8'd128);
        drive(128 * 7, 1, 0, -16'sd32768);
        drive(8, -1, 0, '0);
        check("rate128_min", last_val, min_val);

        // rate=1, ramp every cycle
        restart(8'd1);
        drive(60, 1, 1, '0);

        // rate=10, strobe every 3rd cycle
        restart(8'd10);
        drive(200, 3, 2, '0);

        // rate=0 behaves as 1, random strobes
        restart(8'd0);
        drive(50, 0, 2, '0);

        // enable drop mid-group
        restart(8'd5);
        drive(37, 0, 2, '0);
        @(negedge clock);
        enable = 1'b0;
        drive(3, -1, 2, '0);
        enable = 1'b1;
        drive(60, 0, 2, '0);

        // rate change 8 -> 3 mid-group (counter at 5), pipeline drained first
        restart(8'd8);
        drive(8 * 2 + 5, 1, 2, '0);
        drive(10, -1, 2, '0);
        rate          = 8'd3;
        first_out_cyc = -1;
        first_stb_cyc = -1;
        drive(1, -1, 2, '0);
        drive(40, 1, 2, '0);
`ifdef CIC_DEC_RATE_RESYNC_EN
        k_exp = 3;
`else
        k_exp = 1;
`endif
        check("rate_change_first_out_cyc", W'(first_out_cyc),
              W'(first_stb_cyc + k_exp - 1 + N + 1));

        // random strobes at a mid rate for extra coverage
        restart(8'd7);
        drive(150, 0, 2, '0);

        drive(12, -1, 0, '0);
        check("queue_drained", W'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
